// File: rtl/icb_slave_mem_model.sv
// icb_slave_mem_model
// Parametrised ICB slave memory responder. Commands are decoded and executed
// at the accept edge (writes land in the array, reads snapshot the array into
// an in-order response queue). Each queue entry ages until LATENCY, then the
// head is presented on a registered response port. Also provides address
// range/alignment error reporting, injectable command backpressure and
// saturating transaction counters.
// rst_n keeps its legacy name but is asynchronous and ACTIVE-HIGH.

module icb_slave_mem_model #(
  parameter int unsigned   DW          = 32,
  parameter int unsigned   AW          = 32,
  parameter int unsigned   DEPTH       = 1024,
  parameter logic [AW-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned   LATENCY     = 2,
  parameter int unsigned   OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         icb_cmd_valid,
  output logic                         icb_cmd_ready,
  input  logic                         icb_cmd_read,
  input  logic [AW-1:0]                icb_cmd_addr,
  input  logic [DW-1:0]                icb_cmd_wdata,
  input  logic [DW/8-1:0]              icb_cmd_wmask,
  output logic                         icb_rsp_valid,
  input  logic                         icb_rsp_ready,
  output logic [DW-1:0]                icb_rsp_rdata,
  output logic                         icb_rsp_err,
  input  logic                         cfg_stall,
  output logic [$clog2(OUTSTANDING):0] pending_cnt,
  output logic [15:0]                  rd_cnt,
  output logic [15:0]                  wr_cnt,
  output logic [15:0]                  err_cnt
);

  localparam int BW   = int'(DW / 8);
  localparam int OB   = $clog2(BW);
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW   = $clog2(OUTSTANDING) + 1;
  localparam int AGW  = 4;
  localparam int AW1  = int'(AW) + 1;

  // Size of the decoded window in bytes, one bit wider than the address so
  // a window reaching the top of the address space still compares correctly.
  localparam logic [AW:0]    MEM_SPAN = AW1'(DEPTH) * AW1'(BW);
  localparam logic [AGW-1:0] AGE_MAX  = AGW'(LATENCY);

  typedef enum logic [1:0] {
    CMD_RD,
    CMD_WR,
    CMD_ERR
  } cmd_kind_e;

  typedef struct packed {
    logic [DW-1:0]  rdata;
    logic           err;
    logic [AGW-1:0] age;
  } entry_t;

  // Wrap-around pointer increment that also works for non-power-of-2 depths
  // of the pointer field (OUTSTANDING = 1 still uses a 1-bit pointer).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [DW-1:0]    mem_q [DEPTH];

  entry_t           q_q [OUTSTANDING];
  entry_t           q_d [OUTSTANDING];
  logic [OUTSTANDING-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [15:0]      rd_cnt_q, wr_cnt_q, err_cnt_q;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0]    offset;
  logic             addr_err;
  logic [IW-1:0]    word_idx;
  logic [DW-1:0]    mem_rdata;
  cmd_kind_e        cmd_kind;
  logic             accept;
  logic             retire;
  logic             head_live;

  assign offset    = icb_cmd_addr - BASE_ADDR;
  assign addr_err  = (icb_cmd_addr < BASE_ADDR)
                  || ({1'b0, offset} >= MEM_SPAN)
                  || ((offset & AW'(BW - 1)) != '0);
  assign word_idx  = IW'(offset >> OB);
  assign mem_rdata = mem_q[word_idx];
  assign cmd_kind  = addr_err ? CMD_ERR : (icb_cmd_read ? CMD_RD : CMD_WR);

  // Ready depends only on the stall input and registered occupancy, so the
  // master may legally wait for ready before raising valid.
  assign icb_cmd_ready = !cfg_stall && (cnt_q < CW'(OUTSTANDING));
  assign accept        = icb_cmd_valid && icb_cmd_ready;
  assign retire        = rsp_valid_q && icb_rsp_ready;

  // ---------------------------------------------------------------------------
  // Memory array
  // ---------------------------------------------------------------------------
  // Byte-masked write of a good write command at its accept edge.
  // NOTE: the array has no reset branch; clearing thousands of words would
  // need a reset fan-out into every bit and stops RAM inference, and contents
  // written before a reset are expected to survive it.
  always_ff @(posedge clk) begin
    if (accept && (cmd_kind == CMD_WR)) begin
      for (int b = 0; b < BW; b++) begin
        if (icb_cmd_wmask[b]) begin
          mem_q[word_idx][b*8 +: 8] <= icb_cmd_wdata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response queue next state
  // ---------------------------------------------------------------------------
  // Age live entries, pop on retire, push on accept, track occupancy.
  // NOTE: every signal gets a default at the top of the block so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    q_d      = q_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    for (int i = 0; i < OUTSTANDING; i++) begin
      if (vld_q[i] && (q_q[i].age < AGE_MAX)) begin
        q_d[i].age = q_q[i].age + 1'b1;
      end
    end

    if (retire) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end

    if (accept) begin
      vld_d[wr_ptr_q]     = 1'b1;
      q_d[wr_ptr_q].age   = AGW'(1);
      q_d[wr_ptr_q].err   = addr_err;
      q_d[wr_ptr_q].rdata = (cmd_kind == CMD_RD) ? mem_rdata : '0;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end

    case ({accept, retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response port next state
  // ---------------------------------------------------------------------------
  // Hold while stalled; otherwise present the (post-retire) head once it has
  // aged to LATENCY, giving back-to-back responses with no bubble.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    // The entry at the new head must have been queued before this edge and
    // must not be the one retiring now (only possible with OUTSTANDING = 1).
    head_live   = vld_q[rd_ptr_d] && !(retire && (rd_ptr_d == rd_ptr_q));

    if (!rsp_valid_q || icb_rsp_ready) begin
      rsp_valid_d = head_live && (q_q[rd_ptr_d].age >= AGE_MAX);
      rsp_rdata_d = rsp_valid_d ? q_q[rd_ptr_d].rdata : '0;
      rsp_err_d   = rsp_valid_d && q_q[rd_ptr_d].err;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // Queue, pointers, occupancy and registered response outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        q_q[i] <= '0;
      end
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      q_q         <= q_d;
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Saturating per-kind transaction counters, bumped on accept.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (accept) begin
      case (cmd_kind)
        CMD_RD:  rd_cnt_q  <= sat_inc(rd_cnt_q);
        CMD_WR:  wr_cnt_q  <= sat_inc(wr_cnt_q);
        default: err_cnt_q <= sat_inc(err_cnt_q);
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign icb_rsp_err   = rsp_err_q;
  assign pending_cnt   = cnt_q;
  assign rd_cnt        = rd_cnt_q;
  assign wr_cnt        = wr_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_icb_slave_mem_model.sv
// tb_icb_slave_mem_model
// Directed bench for icb_slave_mem_model with default parameters
// (DW=32, DEPTH=1024, BASE=0x1000_0000, LATENCY=2, OUTSTANDING=4).
// Inputs change and outputs are sampled 1 ns or more after the rising edge.

module tb_icb_slave_mem_model;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_read = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wmask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cfg_stall = 1'b0;
  logic [2:0]  pending_cnt;
  logic [15:0] rd_cnt, wr_cnt, err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  icb_slave_mem_model #(
    .DW(32), .AW(32), .DEPTH(1024), .BASE_ADDR(32'h1000_0000),
    .LATENCY(LAT), .OUTSTANDING(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icb_cmd_valid (cmd_valid),
    .icb_cmd_ready (cmd_ready),
    .icb_cmd_read  (cmd_read),
    .icb_cmd_addr  (cmd_addr),
    .icb_cmd_wdata (cmd_wdata),
    .icb_cmd_wmask (cmd_wmask),
    .icb_rsp_valid (rsp_valid),
    .icb_rsp_ready (rsp_ready),
    .icb_rsp_rdata (rsp_rdata),
    .icb_rsp_err   (rsp_err),
    .cfg_stall     (cfg_stall),
    .pending_cnt   (pending_cnt),
    .rd_cnt        (rd_cnt),
    .wr_cnt        (wr_cnt),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_cnts(input string tag, input int rd, input int wr, input int er);
    check({tag, "_rd_cnt"},  32'(rd_cnt),  32'(rd));
    check({tag, "_wr_cnt"},  32'(wr_cnt),  32'(wr));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(er));
  endtask

  // Present one command and return just after its accept edge.
  task automatic do_cmd(input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask);
    int waited;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wmask = mask;
    #1;
    while (!cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called just after an accept edge with an otherwise empty queue and
  // rsp_ready=1: response must appear exactly LAT edges later, then retire.
  task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic err);
    for (int i = 0; i < LAT; i++) begin
      check({tag, "_early"}, 32'(rsp_valid), 32'd0);
      tick();
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_rdata"}, rsp_rdata, rdata);
    check({tag, "_err"},   32'(rsp_err), 32'(err));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values ----------------
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    check("rst_pending",   32'(pending_cnt), 32'd0);
    check_cnts("rst", 0, 0, 0);
    rst_n = 1'b0;
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---------------- basic write / read, latency ----------------
    do_cmd(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    expect_rsp("wr1", 32'h0, 1'b0);
    do_cmd(1'b1, BASE + 32'h10, 32'h0, 4'h0);
    check("rd1_pending", 32'(pending_cnt), 32'd1);
    expect_rsp("rd1", 32'hDEAD_BEEF, 1'b0);
    check("rd1_pending_done", 32'(pending_cnt), 32'd0);
    check_cnts("basic", 1, 1, 0);

    // ---------------- byte masks ----------------
    do_cmd(1'b0, BASE + 32'h20, 32'h1122_3344, 4'hF);
    expect_rsp("pre", 32'h0, 1'b0);
    do_cmd(1'b0, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
    expect_rsp("mwr", 32'h0, 1'b0);
    do_cmd(1'b1, BASE + 32'h20, 32'h0, 4'h0);
    expect_rsp("mrd", 32'h11BB_33DD, 1'b0);
    do_cmd(1'b0, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0);
    expect_rsp("zwr", 32'h0, 1'b0);
    do_cmd(1'b1, BASE + 32'h20, 32'h0, 4'h0);
    expect_rsp("zrd", 32'h11BB_33DD, 1'b0);

    // ---------------- read right after write, no bubble ----------------
    do_cmd(1'b0, BASE + 32'h30, 32'h5A5A_5A5A, 4'hF);
    do_cmd(1'b1, BASE + 32'h30, 32'h0, 4'h0);
    tick();
    check("b2b_wr_valid", 32'(rsp_valid), 32'd1);
    check("b2b_wr_rdata", rsp_rdata, 32'h0);
    tick();
    check("b2b_rd_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rd_rdata", rsp_rdata, 32'h5A5A_5A5A);
    tick();
    check("b2b_idle", 32'(rsp_valid), 32'd0);
    check_cnts("mask", 4, 5, 0);

    // ---------------- address errors and window edges ----------------
    do_cmd(1'b0, BASE, 32'h0BAD_F00D, 4'hF);
    expect_rsp("w0", 32'h0, 1'b0);
    do_cmd(1'b0, BASE + 32'hFFC, 32'hC0FF_EE00, 4'hF);
    expect_rsp("wlast", 32'h0, 1'b0);
    do_cmd(1'b1, 32'h0FFF_FFFC, 32'h0, 4'h0);
    expect_rsp("err_low", 32'h0, 1'b1);
    do_cmd(1'b0, BASE + 32'h2, 32'hFFFF_FFFF, 4'hF);
    expect_rsp("err_align", 32'h0, 1'b1);
    do_cmd(1'b1, BASE + 32'h1000, 32'h0, 4'h0);
    expect_rsp("err_high", 32'h0, 1'b1);
    do_cmd(1'b1, BASE, 32'h0, 4'h0);
    expect_rsp("r0_unchanged", 32'h0BAD_F00D, 1'b0);
    do_cmd(1'b1, BASE + 32'hFFC, 32'h0, 4'h0);
    expect_rsp("rlast", 32'hC0FF_EE00, 1'b0);
    check_cnts("err", 6, 7, 3);

    // ---------------- backpressure, OUTSTANDING = 4 ----------------
    for (int k = 0; k < 6; k++) begin
      do_cmd(1'b0, BASE + 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'hF);
      expect_rsp("bp_pre", 32'h0, 1'b0);
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_read  = 1'b1;
    cmd_wmask = '0;
    cmd_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      cmd_addr = BASE + 32'h100 + 32'(4 * k);
      #1;
      check("bp_ready_not_full", 32'(cmd_ready), 32'd1);
      tick();
    end
    cmd_addr = BASE + 32'h110;
    #1;
    check("bp_full_ready", 32'(cmd_ready), 32'd0);
    check("bp_full_pending", 32'(pending_cnt), 32'd4);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_rdata", rsp_rdata, 32'hA000_0000);
      check("bp_hold_pending", 32'(pending_cnt), 32'd4);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hA000_0000 + 32'(i));
      if (i == 0) check("bp_ready_pre_retire", 32'(cmd_ready), 32'd0);
      if (i == 1) begin
        check("bp_ready_post_retire", 32'(cmd_ready), 32'd1);
        check("bp_pending_post_retire", 32'(pending_cnt), 32'd3);
      end
      if (i == 2) cmd_addr = BASE + 32'h114;
      if (i == 3) begin
        cmd_valid = 1'b0;
        check("bp_pending_steady", 32'(pending_cnt), 32'd3);
      end
      tick();
    end
    check("bp_drained_valid", 32'(rsp_valid), 32'd0);
    check("bp_drained_pending", 32'(pending_cnt), 32'd0);
    check_cnts("bp", 12, 13, 3);

    // ---------------- cfg_stall ----------------
    cfg_stall = 1'b1;
    cmd_valid = 1'b1;
    cmd_read  = 1'b1;
    cmd_addr  = BASE;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    check("stall_pending", 32'(pending_cnt), 32'd0);
    check_cnts("stall", 12, 13, 3);
    cfg_stall = 1'b0;
    #1;
    check("unstall_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("unstall_pending", 32'(pending_cnt), 32'd1);
    check("unstall_rd_cnt", 32'(rd_cnt), 32'd13);
    expect_rsp("unstall_rsp", 32'h0BAD_F00D, 1'b0);

    // ---------------- reset mid-flight ----------------
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_read  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_addr = BASE + 32'h100 + 32'(4 * k);
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_pending", 32'(pending_cnt), 32'd3);
    check("mid_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_pending", 32'(pending_cnt), 32'd0);
    check_cnts("mid_rst", 0, 0, 0);
    tick();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    do_cmd(1'b1, BASE + 32'h104, 32'h0, 4'h0);
    check("post_rst_rd_cnt", 32'(rd_cnt), 32'd1);
    expect_rsp("post_rst", 32'hA000_0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icb_slave_mem_model.md
Name: icb_slave_mem_model

Overview:
- Parametrised, synthesizable ICB slave memory used as the accelerator's external-memory responder in the next-generation bench and in FPGA prototypes.
- Generalises the fixed ICB slave interface to configurable data width, memory depth, response latency and number of outstanding commands.
- Adds byte-masked writes, address-range error reporting, injectable command backpressure and transaction counters.

Parameters:
DW, 32, data width in bits; multiple of 8
AW, 32, address width in bits
DEPTH, 1024, memory depth in DW-bit words; power of 2
BASE_ADDR, 32'h1000_0000, byte address of word 0
LATENCY, 2, cycles from command accept to earliest rsp_valid; legal range 1..15
OUTSTANDING, 4, max accepted-but-unretired commands; power of 2, ≥1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous, active-high
icb_cmd_valid  in  1  command valid
icb_cmd_ready  out  1  command ready
icb_cmd_read  in  1  1 = read, 0 = write
icb_cmd_addr  in  AW  byte address
icb_cmd_wdata  in  DW  write data
icb_cmd_wmask  in  DW/8  byte enables
icb_rsp_valid  out  1  response valid
icb_rsp_ready  in  1  response ready
icb_rsp_rdata  out  DW  read data; 0 for writes and errors
icb_rsp_err  out  1  response error
cfg_stall  in  1  forces icb_cmd_ready low while high
pending_cnt  out  $clog2(OUTSTANDING)+1  outstanding commands
rd_cnt  out  16  accepted good reads, saturating
wr_cnt  out  16  accepted good writes, saturating
err_cnt  out  16  accepted erroneous commands, saturating

Behaviour:
Reset:
- rst_n=1 asynchronously clears all queue entries, pointers, ages, pending_cnt and counters to 0.
- icb_rsp_valid, icb_rsp_rdata and icb_rsp_err reset to 0.
- Memory array is not reset.
- Reset mid-transaction drops every pending response with no partial handshake; writes already accepted remain in memory.

Command acceptance:
- icb_cmd_ready = !cfg_stall && (pending_cnt < OUTSTANDING). Combinational from cfg_stall and registered state only, never from icb_cmd_valid.
- A command is accepted when icb_cmd_valid && icb_cmd_ready at a rising edge.

Error decode:
- Error when the address lies outside [BASE_ADDR, BASE_ADDR + DEPTH*DW/8) or is not DW/8-byte aligned.
- Erroneous commands are accepted normally: no memory access, response has err=1 and rdata=0, err_cnt increments.

Writes:
- Memory is updated at the accept edge, only bytes with wmask=1.
- wmask=0 is a legal no-op write and still increments wr_cnt.
- Response rdata=0.

Reads:
- Data is sampled from memory at the accept edge and stored in the queue entry.
- A read accepted the cycle after a write to the same word returns the new data.

Response queue:
- In-order FIFO of OUTSTANDING entries holding {rdata, err, age}.
- age starts at 1 on accept and increments each cycle, saturating at LATENCY.
- icb_rsp_valid is registered, asserted when the head entry has age ≥ LATENCY. For a command accepted at edge T with an empty queue, rsp_valid rises at T+LATENCY.
- Response is retired on icb_rsp_valid && icb_rsp_ready. While valid and not ready, rsp_valid, rdata and err hold stable.
- After a retire, the next entry, if already aged, is presented on the following cycle with no bubble. Throughput is one response per cycle.

pending_cnt:
- +1 on accept, −1 on retire, unchanged when both occur in the same cycle.
- Full (pending_cnt = OUTSTANDING) drops ready the same cycle; a retire in that cycle raises ready on the next cycle.

Counters:
- Each counter increments by 1 per qualifying accept and saturates at 16'hFFFF.

Test Plan:
- Defaults, LATENCY=2: write 0xDEADBEEF, mask 4'hF, to 0x1000_0010; read it back → read rsp_valid exactly 2 cycles after accept, rdata=0xDEADBEEF, err=0, wr_cnt=1, rd_cnt=1.
- Byte mask: preload 0x11223344, write 0xAABBCCDD with mask 4'b0101, read → 0x11BB33DD.
- Errors: read at 0x0FFF_FFFC, then write at 0x1000_0002 → both rsp err=1, rdata=0, err_cnt=2, memory unchanged.
- Backpressure: OUTSTANDING=4, rsp_ready=0, 6 back-to-back reads → 4 accepted, cmd_ready=0, pending_cnt=4; rsp_ready=1 → all 6 responses in order, data stable while stalled, ready reasserts the cycle after the first retire.
- cfg_stall=1 for 5 cycles with cmd_valid=1 → no accept, counters unchanged; release → accept on the next edge.
- Reset mid-flight: 3 pending reads, pulse rst_n=1 → rsp_valid=0 and pending_cnt=0 immediately; a subsequent read returns memory data written before the reset.
